// File: rtl/iterative_muldiv_unit.sv
// Radix-2 iterative multiply/divide engine that owns the HI/LO register pair.
// Define MULDIV_EARLY_TERM_EN to build in early termination and divide normalisation.
module iterative_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs_i,
  input  logic [XLEN-1:0] rt_i,
  input  logic            flush_i,
  input  logic            hilo_rd_i,
  input  logic            hilo_we_i,
  input  logic            hilo_sel_i,
  input  logic [XLEN-1:0] hilo_wdata_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;      // product, or {remainder, quotient}
  logic [2*XLEN-1:0] mcand_reg, mcand_next;  // left-shifting multiplicand
  logic [XLEN-1:0]   opb_reg, opb_next;      // multiplier (shifts right) or divisor
  logic              is_div_reg, is_div_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;
  logic              div0_reg, div0_next;
  logic [XLEN-1:0]   hi_reg, hi_next;
  logic [XLEN-1:0]   lo_reg, lo_next;
  logic              done_reg, done_next;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [CNT_W-1:0]  norm_shift;
  logic [XLEN:0]     rem_shift, trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              calc_last;

  assign sign_a = ~op_i[0] & rs_i[XLEN-1];
  assign sign_b = ~op_i[0] & rt_i[XLEN-1];
  assign abs_a  = sign_a ? -rs_i : rs_i;
  assign abs_b  = sign_b ? -rt_i : rt_i;

`ifdef MULDIV_EARLY_TERM_EN
  // Leading zeros of the dividend magnitude, capped so at least one step remains.
  logic lead_found;
  always_comb begin
    norm_shift = '0;
    lead_found = 1'b0;
    for (int i = XLEN - 1; i > 0; i--) begin
      if (!lead_found && !abs_a[i]) norm_shift = norm_shift + CNT_W'(1);
      else lead_found = 1'b1;
    end
  end
`else
  assign norm_shift = '0;
`endif

  // Restoring step: shift the next dividend bit into the remainder and trial-subtract.
  assign rem_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign trial     = rem_shift - {1'b0, opb_reg};

  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quo_fix  = div0_reg  ? {XLEN{1'b1}}
                  : (neg_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0]);
  assign rem_fix  = neg_r_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      opb_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      opb_reg    <= opb_next;
      is_div_reg <= is_div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      div0_reg   <= div0_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    opb_next    = opb_reg;
    is_div_next = is_div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    div0_next   = div0_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;
    calc_last   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (hilo_we_i) begin
          if (hilo_sel_i) hi_next = hilo_wdata_i;
          else            lo_next = hilo_wdata_i;
        end
        if (start_i && !flush_i) begin
          state_next  = S_CALC;
          is_div_next = op_i[1];
          neg_q_next  = sign_a ^ sign_b;
          neg_r_next  = sign_a;
          div0_next   = op_i[1] && (rt_i == '0);
          opb_next    = abs_b;
          if (op_i[1]) begin
            acc_next   = {{XLEN{1'b0}}, abs_a << norm_shift};
            mcand_next = '0;
            cnt_next   = norm_shift;
          end else begin
            acc_next   = '0;
            mcand_next = {{XLEN{1'b0}}, abs_a};
            cnt_next   = '0;
          end
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (is_div_reg) begin
            if (!trial[XLEN]) acc_next = {trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
            else              acc_next = {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
          end else begin
            if (opb_reg[0]) acc_next = acc_reg + mcand_reg;
            mcand_next = mcand_reg << 1;
            opb_next   = opb_reg >> 1;
          end
          calc_last = (cnt_next == CNT_LAST);
`ifdef MULDIV_EARLY_TERM_EN
          if (!is_div_reg && opb_next == '0) calc_last = 1'b1;
`endif
          if (calc_last) state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
        if (!flush_i) begin
          done_next = 1'b1;
          if (is_div_reg) begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end else begin
            hi_next = prod_fix[2*XLEN-1:XLEN];
            lo_next = prod_fix[XLEN-1:0];
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_o  = (state_reg != S_IDLE);
  assign stall_o = busy_o & (start_i | hilo_rd_i | hilo_we_i);
  assign done_o  = done_reg;
  assign hi_o    = hi_reg;
  assign lo_o    = lo_reg;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Directed and randomised checks of iterative_muldiv_unit against an arithmetic model.
module tb_iterative_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs_i, rt_i;
  logic            flush_i, hilo_rd_i, hilo_we_i, hilo_sel_i;
  logic [XLEN-1:0] hilo_wdata_i;
  logic            busy_o, stall_o, done_o;
  logic [XLEN-1:0] hi_o, lo_o;

  int vectors = 0;
  int fails = 0;
  int lat = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic [31:0] pend_hi, pend_lo;
  logic [31:0] a, b;
  logic [1:0]  op;
  bit          seen;

  iterative_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .flush_i(flush_i), .hilo_rd_i(hilo_rd_i), .hilo_we_i(hilo_we_i), .hilo_sel_i(hilo_sel_i),
    .hilo_wdata_i(hilo_wdata_i), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no end, expected $finish");
    $fatal(1);
  end

  // Reference result {HI, LO} computed with plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int q, r;
    case (mop)
      2'd0: begin p = longint'(int'(x)) * longint'(int'(y)); return p; end
      2'd1: return {32'h0, x} * {32'h0, y};
      2'd2: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = int'(x) / int'(y);
        r = int'(x) % int'(y);
        return {r, q};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lat++;
  endtask

  task automatic issue(input logic [1:0] iop, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    r = model(iop, x, y);
    pend_hi = r[63:32];
    pend_lo = r[31:0];
    op_i = iop; rs_i = x; rt_i = y; start_i = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    start_i = 1'b0;
    hilo_we_i = 1'b0;
  endtask

  task automatic finish_op(input string tag);
    bit busy_ok;
    busy_ok = 1'b1;
    while (done_o !== 1'b1 && lat < XLEN + 3) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      tick();
    end
    check({tag, "_busy_while_calc"}, 64'(busy_ok), 64'd1);
    check({tag, "_done"}, 64'(done_o), 64'd1);
`ifdef MULDIV_EARLY_TERM_EN
    check({tag, "_latency_range"}, 64'(lat >= 3 && lat <= XLEN + 2), 64'd1);
`else
    check({tag, "_latency"}, 64'(lat), 64'(XLEN + 2));
`endif
    exp_hi = pend_hi;
    exp_lo = pend_lo;
    check({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
    check({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
    tick();
    check({tag, "_done_single"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; op_i = 2'd0; rs_i = '0; rt_i = '0;
    flush_i = 1'b0; hilo_rd_i = 1'b0; hilo_we_i = 1'b0; hilo_sel_i = 1'b0; hilo_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // mthi / mtlo in IDLE
    hilo_we_i = 1'b1; hilo_sel_i = 1'b1; hilo_wdata_i = 32'h1234;
    tick();
    hilo_we_i = 1'b0;
    exp_hi = 32'h1234;
    check("mthi_hi", 64'(hi_o), 64'(exp_hi));
    check("mthi_lo", 64'(lo_o), 64'(exp_lo));
    hilo_we_i = 1'b1; hilo_sel_i = 1'b0; hilo_wdata_i = 32'hCAFE0001;
    tick();
    hilo_we_i = 1'b0;
    exp_lo = 32'hCAFE0001;
    check("mtlo_lo", 64'(lo_o), 64'(exp_lo));
    check("mtlo_hi", 64'(hi_o), 64'(exp_hi));

    // Directed operations
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); finish_op("multu_max");
    check("multu_max_const_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFE);
    issue(2'd0, 32'hFFFFFFFD, 32'd7);        finish_op("mult_neg3x7");
    issue(2'd2, 32'hFFFFFFF9, 32'd2);        finish_op("div_neg7by2");
    issue(2'd3, 32'd7, 32'd0);               finish_op("divu_by0");
    issue(2'd2, 32'hFFFFFFF9, 32'd0);        finish_op("div_neg_by0");
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF); finish_op("div_overflow");
    issue(2'd1, 32'd5, 32'd3);               finish_op("multu_5x3");
`ifdef MULDIV_EARLY_TERM_EN
    check("multu_5x3_early", 64'(lat <= 6), 64'd1);
`endif
    issue(2'd0, 32'h80000000, 32'h80000000); finish_op("mult_min_min");
    issue(2'd2, 32'd100, 32'hFFFFFFF9);      finish_op("div_100_neg7");

    // Stall requests while busy; a start held across an edge must not be accepted
    issue(2'd3, 32'd1000, 32'd3);
    repeat (4) tick();
    hilo_rd_i = 1'b1; #1;
    check("stall_on_mfhi", 64'(stall_o), 64'd1);
    hilo_rd_i = 1'b0; hilo_we_i = 1'b1; #1;
    check("stall_on_mthi", 64'(stall_o), 64'd1);
    hilo_we_i = 1'b0; #1;
    check("stall_idle_req", 64'(stall_o), 64'd0);
    op_i = 2'd1; rs_i = 32'd9; rt_i = 32'd9; start_i = 1'b1; #1;
    check("stall_on_start", 64'(stall_o), 64'd1);
    tick();
    start_i = 1'b0;
    finish_op("divu_stalled");

    // Flush mid-multiply: no result, HI/LO keep prior values
    issue(2'd1, 32'h0000FFFF, 32'h0000FFFF);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    seen = 1'b0;
    repeat (40) begin tick(); if (done_o === 1'b1) seen = 1'b1; end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi", 64'(hi_o), 64'(exp_hi));
    check("flush_lo", 64'(lo_o), 64'(exp_lo));

    // Flush together with start in IDLE: start ignored
    op_i = 2'd1; rs_i = 32'd2; rt_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_busy", 64'(busy_o), 64'd0);
    seen = 1'b0;
    repeat (XLEN + 4) begin tick(); if (done_o === 1'b1) seen = 1'b1; end
    check("flush_start_no_done", 64'(seen), 64'd0);

    // mtlo with start: write lands now, result overwrites later
    hilo_we_i = 1'b1; hilo_sel_i = 1'b0; hilo_wdata_i = 32'hAAAA5555;
    issue(2'd1, 32'd6, 32'd7);
    check("we_start_lo_now", 64'(lo_o), 64'h0000_0000_AAAA_5555);
    check("we_start_busy", 64'(busy_o), 64'd1);
    finish_op("we_start_result");

    // Randomised operations
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        3: begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
      issue(op, a, b);
      finish_op($sformatf("rand%0d_op%0d", n, op));
    end

    // Asynchronous reset in the middle of a divide
    hilo_we_i = 1'b1; hilo_sel_i = 1'b1; hilo_wdata_i = 32'h1234;
    tick();
    hilo_we_i = 1'b0;
    issue(2'd2, 32'd100, 32'd7);
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_done", 64'(done_o), 64'd0);
    check("rst_mid_hi", 64'(hi_o), 64'(exp_hi));
    check("rst_mid_lo", 64'(lo_o), 64'(exp_lo));
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (XLEN + 4) begin tick(); if (done_o === 1'b1 || busy_o === 1'b1) seen = 1'b1; end
    check("rst_mid_no_resume", 64'(seen), 64'd0);
    issue(2'd3, 32'd100, 32'd7);
    finish_op("after_reset_divu");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
